// File: rtl/vp_pkg.sv
// Shared definitions for the vector load unit.
//   - Geometry constants: DATA_W, WORD_W, WORDS, ADDR_W, SEL_W and derived widths.
//   - vlu_state_e: FSM states of vector_load_unit.
//   - word_addr(): byte address of word idx for a (base, stride) load.
package vp_pkg;

    localparam int DATA_W     = 512;
    localparam int WORD_W     = 32;
    localparam int WORDS      = DATA_W / WORD_W;
    localparam int ADDR_W     = 32;
    localparam int SEL_W      = 2;
    localparam int WORD_BYTES = WORD_W / 8;
    // Counters must reach WORDS itself, so one extra bit over the lane index.
    localparam int CNT_W      = $clog2(WORDS + 1);
    localparam int LANE_W     = $clog2(WORDS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WRITE = 2'd2
    } vlu_state_e;

    // Address arithmetic wraps modulo 2^ADDR_W by truncation.
    function automatic logic [ADDR_W-1:0] word_addr(
        input logic [ADDR_W-1:0] base,
        input logic [CNT_W-1:0]  idx,
        input logic [ADDR_W-1:0] stride
    );
        logic [ADDR_W-1:0] idx_ext;
        idx_ext = ADDR_W'(idx);
        return base + idx_ext * stride * ADDR_W'(WORD_BYTES);
    endfunction

endpackage

// File: rtl/vlu_assembler.sv
// Vector assembly buffer for the vector load unit.
// Holds WORDS lanes of WORD_W bits; one lane is written per cycle through a
// lane-indexed port. There is no clear between loads: every lane is
// overwritten by the next load before it is read out.
// Ports:
//   clk        in   clock
//   rst_n      in   asynchronous active-low reset (buffer cleared to 0)
//   wr_en_i    in   lane write enable
//   wr_lane_i  in   lane index (lane 0 = bits [WORD_W-1:0])
//   wr_data_i  in   lane data
//   vec_o      out  assembled DATA_W vector
module vlu_assembler
    import vp_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en_i,
    input  logic [LANE_W-1:0] wr_lane_i,
    input  logic [WORD_W-1:0] wr_data_i,
    output logic [DATA_W-1:0] vec_o
);

    logic [WORDS-1:0][WORD_W-1:0] vec_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_q <= '0;
        end else if (wr_en_i) begin
            vec_q[wr_lane_i] <= wr_data_i;
        end
    end

    assign vec_o = vec_q;

endmodule

// File: rtl/vector_load_unit.sv
// Vector load unit: fetches WORDS consecutive memory words for one load
// command, assembles them into a DATA_W vector and writes it to the
// register file's second write port for a single cycle.
// Optional feature macro: VLU_STRIDE_EN (latch cmd_stride as the word
// stride; otherwise the stride is fixed at 1 and cmd_stride is unused).
// Ports:
//   clk, reset            clock; asynchronous active-low reset
//   cmd_valid/cmd_ready   load command handshake; cmd_dst, cmd_base, cmd_stride
//   mem_req_valid/ready   read request handshake; mem_req_addr
//   mem_rsp_valid         in-order read data strobe; mem_rsp_data
//   write_en2/sel2/data2  register-file write port (one-cycle strobe)
//   busy, done            command in flight; completion pulse with write_en2
//   dbg_state_o           current FSM state
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. The unit's valids and the request address depend only on
// registered state, so they are stable while the partner stalls; responses
// carry no ready and are accepted whenever valid in FETCH with lanes left.
module vector_load_unit
    import vp_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [SEL_W-1:0]  cmd_dst,
    input  logic [ADDR_W-1:0] cmd_base,
    input  logic [ADDR_W-1:0] cmd_stride,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_rsp_valid,
    input  logic [WORD_W-1:0] mem_rsp_data,
    output logic              write_en2,
    output logic [SEL_W-1:0]  write_sel2,
    output logic [DATA_W-1:0] write_data2,
    output logic              busy,
    output logic              done,
    output vlu_state_e        dbg_state_o
);

    vlu_state_e        state_q, state_d;
    logic [SEL_W-1:0]  dst_q, dst_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [CNT_W-1:0]  req_cnt_q, req_cnt_d;
    logic [CNT_W-1:0]  rsp_cnt_q, rsp_cnt_d;
    logic [ADDR_W-1:0] stride_w;
    logic [DATA_W-1:0] vec_w;
    logic              req_fire;
    logic              rsp_take;

`ifdef VLU_STRIDE_EN
    logic [ADDR_W-1:0] stride_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stride_q <= '0;
        end else if (state_q == IDLE && cmd_valid) begin
            stride_q <= cmd_stride;
        end
    end

    assign stride_w = stride_q;
`else
    logic unused_stride;
    assign unused_stride = ^cmd_stride;
    assign stride_w      = ADDR_W'(1);
`endif

    // Responses outside FETCH or beyond the last lane are dropped; this also
    // discards stragglers from a load that was aborted by reset.
    assign req_fire = mem_req_valid && mem_req_ready;
    assign rsp_take = (state_q == FETCH) && mem_rsp_valid
                      && (rsp_cnt_q != CNT_W'(WORDS));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            dst_q     <= '0;
            base_q    <= '0;
            req_cnt_q <= '0;
            rsp_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            dst_q     <= dst_d;
            base_q    <= base_d;
            req_cnt_q <= req_cnt_d;
            rsp_cnt_q <= rsp_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        dst_d     = dst_q;
        base_d    = base_q;
        req_cnt_d = req_cnt_q;
        rsp_cnt_d = rsp_cnt_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    state_d   = FETCH;
                    dst_d     = cmd_dst;
                    base_d    = cmd_base;
                    req_cnt_d = '0;
                    rsp_cnt_d = '0;
                end
            end
            FETCH: begin
                if (req_fire) begin
                    req_cnt_d = req_cnt_q + CNT_W'(1);
                end
                if (rsp_take) begin
                    rsp_cnt_d = rsp_cnt_q + CNT_W'(1);
                    if (rsp_cnt_q == CNT_W'(WORDS - 1)) begin
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    vlu_assembler u_asm (
        .clk       (clk),
        .rst_n     (reset),
        .wr_en_i   (rsp_take),
        .wr_lane_i (rsp_cnt_q[LANE_W-1:0]),
        .wr_data_i (mem_rsp_data),
        .vec_o     (vec_w)
    );

    assign mem_req_valid = (state_q == FETCH) && (req_cnt_q < CNT_W'(WORDS));
    assign mem_req_addr  = mem_req_valid ? word_addr(base_q, req_cnt_q, stride_w)
                                         : '0;
    assign cmd_ready     = (state_q == IDLE);
    assign busy          = !cmd_ready;
    assign write_en2     = (state_q == WRITE);
    assign done          = write_en2;
    assign write_sel2    = write_en2 ? dst_q : '0;
    assign write_data2   = write_en2 ? vec_w : '0;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_vector_load_unit.sv
// Directed testbench for vector_load_unit.
module tb_vector_load_unit;
    import vp_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [SEL_W-1:0]  cmd_dst;
    logic [ADDR_W-1:0] cmd_base;
    logic [ADDR_W-1:0] cmd_stride;
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_rsp_valid;
    logic [WORD_W-1:0] mem_rsp_data;
    logic              write_en2;
    logic [SEL_W-1:0]  write_sel2;
    logic [DATA_W-1:0] write_data2;
    logic              busy;
    logic              done;
    vlu_state_e        dbg_state;

    int total = 0;
    int bad   = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    vector_load_unit dut (
        .clk           (clk),
        .reset         (reset),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_dst       (cmd_dst),
        .cmd_base      (cmd_base),
        .cmd_stride    (cmd_stride),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .write_en2     (write_en2),
        .write_sel2    (write_sel2),
        .write_data2   (write_data2),
        .busy          (busy),
        .done          (done),
        .dbg_state_o   (dbg_state)
    );

    // ---------------- scoreboard ----------------
    task automatic chk(input string tag, input logic [DATA_W-1:0] obs,
                       input logic [DATA_W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver: one complete load ----------------
    // rdy_mode: 0 always ready, 1 toggling, 2 random.  gap_mode: 0 none, 1 random.
    // abort_after > 0 returns once that many responses have been delivered.
    // exp_lat >= 0 checks accept-to-write_en2 cycles.
    task automatic run_load(input logic [SEL_W-1:0] dst, input logic [31:0] base,
                            input logic [31:0] stride_in, input logic [31:0] exp_stride,
                            input logic [31:0] seed, input int rdy_mode,
                            input int gap_mode, input int abort_after, input int exp_lat);
        logic [WORD_W-1:0] exp_q[$];
        int                exp_at[$];
        logic [DATA_W-1:0] exp_vec;
        logic [31:0]       exp_addr;
        logic [31:0]       prev_addr;
        logic              prev_stall;
        int                n, req_n, rsp_n, wr_n;
        bit                fin, aborted;

        for (int i = 0; i < WORDS; i++) begin
            exp_vec[i*WORD_W +: WORD_W] = seed + 32'(i) * exp_stride;
        end
        n = 0; req_n = 0; rsp_n = 0; wr_n = 0;
        fin = 0; aborted = 0; prev_stall = 0; prev_addr = '0;

        @(negedge clk);
        chk("cmd_ready_idle", cmd_ready, 1'b1);
        cmd_valid  = 1'b1;
        cmd_dst    = dst;
        cmd_base   = base;
        cmd_stride = stride_in;
        @(posedge clk);

        while (!fin && !aborted && n < 400) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                // A second command offered while busy must not be taken.
                chk("busy_set", busy, 1'b1);
                chk("cmd_ready_busy", cmd_ready, 1'b0);
                cmd_dst  = dst + 2'd1;
                cmd_base = 32'h0BAD_0000;
            end
            if (n == 3) cmd_valid = 1'b0;
            if (abort_after > 0 && rsp_n == abort_after) begin
                mem_rsp_valid = 1'b0;
                mem_req_ready = 1'b0;
                aborted = 1;
            end else begin
                if (prev_stall) begin
                    chk("stall_valid", mem_req_valid, 1'b1);
                    chk("stall_addr", mem_req_addr, prev_addr);
                end
                if (mem_req_valid) begin
                    if (req_n >= WORDS) chk("extra_req", 1'b1, 1'b0);
                    exp_addr = base + 32'(req_n) * 32'd4 * exp_stride;
                    chk($sformatf("req_addr%0d", req_n), mem_req_addr, exp_addr);
                end
                case (rdy_mode)
                    0:       mem_req_ready = 1'b1;
                    1:       mem_req_ready = n[0];
                    default: mem_req_ready = 1'($urandom_range(0, 1));
                endcase
                if (mem_req_valid && mem_req_ready) begin
                    // memory model: word at (addr - base)/4 holds seed + that offset
                    exp_q.push_back(seed + ((mem_req_addr - base) >> 2));
                    exp_at.push_back(n + 1);
                    req_n++;
                end
                prev_stall = mem_req_valid && !mem_req_ready;
                prev_addr  = mem_req_addr;

                if (exp_q.size() > 0 && exp_at[0] <= n &&
                    (gap_mode == 0 || $urandom_range(0, 2) != 0)) begin
                    mem_rsp_valid = 1'b1;
                    mem_rsp_data  = exp_q.pop_front();
                    void'(exp_at.pop_front());
                    rsp_n++;
                end else begin
                    mem_rsp_valid = 1'b0;
                    mem_rsp_data  = 32'hDEAD_BEEF;
                end

                if (write_en2) begin
                    wr_n++;
                    if (wr_n > 1) chk("double_write", 1'b1, 1'b0);
                    chk("write_sel2", write_sel2, dst);
                    chk("write_data2", write_data2, exp_vec);
                    chk("done", done, 1'b1);
                    chk("req_count", req_n, WORDS);
                    chk("rsp_count", rsp_n, WORDS);
                    if (exp_lat >= 0) chk("latency", n, exp_lat);
                end else if (wr_n == 1) begin
                    chk("ready_after", cmd_ready, 1'b1);
                    chk("sel_idle_zero", write_sel2, '0);
                    chk("data_idle_zero", write_data2, '0);
                    fin = 1;
                end
            end
        end
        if (!fin && !aborted) chk("timeout", 1'b0, 1'b1);
        cmd_valid     = 1'b0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reset         = 1'b0;
        cmd_valid     = 1'b0;
        cmd_dst       = '0;
        cmd_base      = '0;
        cmd_stride    = '0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;

        // 1. reset state
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        chk("rst_write_en2", write_en2, 1'b0);
        chk("rst_req_valid", mem_req_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_state", dbg_state, IDLE);
        chk("rst_data", write_data2, '0);
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", cmd_ready, 1'b1);
        chk("post_rst_busy", busy, 1'b0);

        // 2. basic load, minimum latency
        run_load(2'd2, 32'h100, 32'd1, 32'd1, 32'hA0, 0, 0, 0, WORDS + 2);

        // 3. stalled requests and gapped responses
        run_load(2'd1, 32'h2000, 32'd1, 32'd1, 32'h1234_0000, 1, 1, 0, -1);
        run_load(2'd3, 32'h3000, 32'd1, 32'd1, 32'h0000_7000, 2, 1, 0, -1);

        // 4. address wrap-around
        run_load(2'd0, 32'hFFFF_FFF8, 32'd1, 32'd1, 32'h7700, 0, 0, 0, WORDS + 2);

        // 5. reset mid-load, stray responses afterwards
        run_load(2'd1, 32'h800, 32'd1, 32'd1, 32'h3300, 0, 0, 7, -1);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("abort_no_write", write_en2, 1'b0);
        chk("abort_state", dbg_state, IDLE);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = 32'hDEAD_0000 + 32'(i);
            @(negedge clk);
            chk("stray_no_write", write_en2, 1'b0);
            chk("stray_state", dbg_state, IDLE);
            chk("stray_ready", cmd_ready, 1'b1);
        end
        mem_rsp_valid = 1'b0;
        run_load(2'd3, 32'h900, 32'd1, 32'd1, 32'h5500, 0, 0, 0, WORDS + 2);

        // 6. stride handling
`ifdef VLU_STRIDE_EN
        run_load(2'd1, 32'h40, 32'd0, 32'd0, 32'h55, 0, 0, 0, WORDS + 2);
        run_load(2'd2, 32'h1000, 32'd3, 32'd3, 32'h900, 1, 1, 0, -1);
`else
        run_load(2'd2, 32'h1000, 32'd3, 32'd1, 32'h900, 0, 0, 0, WORDS + 2);
`endif

        // ---------------- report ----------------
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
